// File: rtl/aq_idu_id_wbt_ctrl.sv
// WBT sequencer: turns dispatch creates and EX/LSU write-backs into per-entry enables,
// parks colliding write-backs in a small FIFO, and sequences the WBT flush.
module aq_idu_id_wbt_ctrl #(
    parameter int NUM_ENTRY  = 32,
    parameter int PEND_DEPTH = 4
) (
    input  logic                          wb_clk,
    input  logic                          cpurst_b,
    input  logic                          id_create0_vld,
    input  logic [4:0]                    id_create0_idx,
    input  logic                          id_create1_vld,
    input  logic [4:0]                    id_create1_idx,
    input  logic                          iu_yy_xx_cancel,
    input  logic                          wb0_vld,
    input  logic [4:0]                    wb0_idx,
    input  logic                          wb1_vld,
    input  logic [4:0]                    wb1_idx,
    input  logic [2*NUM_ENTRY-1:0]        entry_cnt,
    input  logic                          rtu_flush_req,
    output logic [NUM_ENTRY-1:0]          create0_en_x,
    output logic [NUM_ENTRY-1:0]          create1_en_x,
    output logic [NUM_ENTRY-1:0]          wb_en_x,
    output logic                          rtu_idu_flush_wbt,
    output logic                          ctrl_id_create0_stall,
    output logic                          ctrl_id_create1_stall,
    output logic [$clog2(PEND_DEPTH):0]   ctrl_pend_cnt
);

    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [4:0]       mem_q [PEND_DEPTH];
    logic [4:0]       mem_d [PEND_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   occ_nxt;

    logic       busy, head_vld;
    logic [4:0] head_idx;
    logic       wb0_v, wb0_blk, wb0_gnt, wb0_push;
    logic       wb1_v, wb1_blk, wb1_gnt, wb1_push;
    logic       gstall, c0_vld, c1_vld, c0_sat, c1_sat, stall0, stall1;

    always_comb begin
        // Reset and flush both freeze the merge and creates
        busy     = !cpurst_b | rtu_flush_req | (state_q == FLUSH);
        state_d  = rtu_flush_req ? FLUSH : IDLE;

        head_vld = (cnt_q != '0) & !busy;
        head_idx = mem_q[rd_ptr_q];
        wb0_v    = wb0_vld & (wb0_idx != 5'd0) & !busy;
        wb0_blk  = head_vld & (wb0_idx == head_idx);
        wb0_gnt  = wb0_v & !wb0_blk;
        wb0_push = wb0_v & wb0_blk;
        wb1_v    = wb1_vld & (wb1_idx != 5'd0) & !busy;
        wb1_blk  = (head_vld & (wb1_idx == head_idx)) | (wb0_gnt & (wb1_idx == wb0_idx));
        wb1_gnt  = wb1_v & !wb1_blk;
        wb1_push = wb1_v & wb1_blk;

        wb_en_x = '0;
        if (head_vld) wb_en_x[head_idx] = 1'b1;
        if (wb0_gnt)  wb_en_x[wb0_idx]  = 1'b1;
        if (wb1_gnt)  wb_en_x[wb1_idx]  = 1'b1;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wb0_push) begin
            mem_d[wr_ptr_d] = wb0_idx;
            wr_ptr_d        = wr_ptr_d + 1'b1;
        end
        if (wb1_push) begin
            mem_d[wr_ptr_d] = wb1_idx;
            wr_ptr_d        = wr_ptr_d + 1'b1;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(head_vld);
        occ_nxt  = {1'b0, cnt_q} - (CNT_W+1)'(head_vld)
                 + (CNT_W+1)'(wb0_push) + (CNT_W+1)'(wb1_push);
        cnt_d    = occ_nxt[CNT_W-1:0];
        if (busy) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end

        // Keeping two free slots lets a full collision cycle always be absorbed
        gstall = cnt_q >= CNT_W'(PEND_DEPTH - 2);
        c0_vld = id_create0_vld & (id_create0_idx != 5'd0);
        c1_vld = id_create1_vld & (id_create1_idx != 5'd0);
        c0_sat = (entry_cnt[{id_create0_idx, 1'b1} -: 2] == 2'd2) & !wb_en_x[id_create0_idx];
        c1_sat = (entry_cnt[{id_create1_idx, 1'b1} -: 2] == 2'd2) & !wb_en_x[id_create1_idx];
        stall0 = busy | gstall | (c0_vld & c0_sat);
        stall1 = busy | gstall | (c0_vld & stall0)
               | (c1_vld & (c1_sat | (c0_vld & (id_create1_idx == id_create0_idx))));

        create0_en_x = '0;
        create1_en_x = '0;
        if (c0_vld & !stall0 & !iu_yy_xx_cancel) create0_en_x[id_create0_idx] = 1'b1;
        if (c1_vld & !stall1 & !iu_yy_xx_cancel) create1_en_x[id_create1_idx] = 1'b1;
    end

    always_ff @(posedge wb_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        mem_q <= mem_d;
    end

    pend_no_overflow: assert property (@(posedge wb_clk) disable iff (!cpurst_b)
        occ_nxt <= (CNT_W+1)'(PEND_DEPTH));

    assign rtu_idu_flush_wbt     = (state_q == FLUSH);
    assign ctrl_id_create0_stall = stall0;
    assign ctrl_id_create1_stall = stall1;
    assign ctrl_pend_cnt         = cnt_q;

endmodule
